imem_arbiter: RTL

Shares the single-port instruction memory (2048 × 32-bit words, word-indexed by byte address [12:2]) between the core's fetch stage and the debug interface. Fetch reads get priority. Debug reads and writes get guaranteed bandwidth through a bounded fetch-streak counter. Illegal addresses are rejected with an error response and no memory access. The block sits between the IF stage / debug interface and the memory array, which has a registered read (1-cycle latency).

---
 rtl/imem_arbiter_if.sv | 45 ++++
 rtl/imem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: groups the fetch port, the debug port and the memory-array port
// of the instruction-memory arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding fetch/debug/memory environment.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 11
);
    // Fetch port
    logic                  f_req;
    logic [31:0]           f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [31:0]           f_rdata;
    logic                  f_err;

    // Debug port
    logic                  d_req;
    logic                  d_we;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    logic                  d_err;

    // Memory array port
    logic                  m_en;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [31:0]           m_wdata;
    logic [31:0]           m_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port, registered-read instruction memory between the
// fetch stage and the debug interface. Fetch has priority; a saturating streak counter
// forces a waiting debug request through after MAX_STREAK contended fetch wins.
// Illegal addresses are granted but answered with an error and no memory access.
// Optional feature macro: IMEM_DEBUG_WRITE_EN (when undefined, debug writes are
// rejected as illegal and the memory is never written).
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    // Word aligned and inside the 2^ADDR_WIDTH word window
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> (ADDR_WIDTH + 2)) == 32'd0);
    endfunction

    logic                f_win;
    logic                d_win;
    logic                f_ok;
    logic                d_ok;
    logic                gnt_err;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;

    logic                rsp_valid;
    logic                rsp_debug;
    logic                rsp_read;
    logic                rsp_err;
    logic [31:0]         rsp_data;

    // Legality of each requester's access
    always_comb begin
        f_ok = addr_legal(bus.f_addr);
`ifdef IMEM_DEBUG_WRITE_EN
        d_ok = addr_legal(bus.d_addr);
`else
        // Without write support a debug write is just another illegal access
        d_ok = addr_legal(bus.d_addr) && !bus.d_we;
`endif
    end

    // Arbitration: fetch wins contention until the streak limit is reached
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        if (!reset) begin
            if (bus.f_req && bus.d_req) begin
                if (streak == STREAK_MAX) begin
                    d_win = 1'b1;
                end else begin
                    f_win = 1'b1;
                end
            end else begin
                f_win = bus.f_req;
                d_win = bus.d_req;
            end
        end
        gnt_err = 1'b0;
        if (f_win) begin
            gnt_err = !f_ok;
        end else if (d_win) begin
            gnt_err = !d_ok;
        end
    end

    // Memory-side drive from the winner; illegal winners never touch the array
    always_comb begin
        bus.m_en    = (f_win && f_ok) || (d_win && d_ok);
`ifdef IMEM_DEBUG_WRITE_EN
        bus.m_we    = d_win && d_ok && bus.d_we;
`else
        bus.m_we    = 1'b0;
`endif
        bus.m_addr  = d_win ? bus.d_addr[ADDR_WIDTH+1:2] : bus.f_addr[ADDR_WIDTH+1:2];
        bus.m_wdata = d_win ? bus.d_wdata : 32'd0;
    end

    // Streak next-state: counts contended fetch wins, saturating at the limit
    always_comb begin
        streak_next = streak;
        if (d_win || !bus.d_req) begin
            streak_next = '0;
        end else if (f_win && (streak != STREAK_MAX)) begin
            streak_next = streak + 1'b1;
        end
    end

    // Streak counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else begin
            streak <= streak_next;
        end
    end

    // Response bookkeeping latched on every grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_debug <= 1'b0;
            rsp_read  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= f_win || d_win;
            rsp_debug <= d_win;
            rsp_read  <= !(d_win && bus.d_we);
            rsp_err   <= gnt_err;
        end
    end

    // Grants and responses; reset masks a response still in flight from before it
    always_comb begin
        rsp_data     = (rsp_valid && rsp_read && !rsp_err) ? bus.m_rdata : 32'd0;
        bus.f_gnt    = f_win;
        bus.d_gnt    = d_win;
        bus.f_rvalid = !reset && rsp_valid && !rsp_debug;
        bus.d_rvalid = !reset && rsp_valid && rsp_debug;
        bus.f_err    = bus.f_rvalid && rsp_err;
        bus.d_err    = bus.d_rvalid && rsp_err;
        bus.f_rdata  = bus.f_rvalid ? rsp_data : 32'd0;
        bus.d_rdata  = bus.d_rvalid ? rsp_data : 32'd0;
    end
endmodule
